// File: rtl/mdu_iter_div_pkg.sv
// Shared types for the multiply/divide unit: divider FSM states and the packed
// {quotient, remainder} result that the HI/LO controller writes to {LO, HI}.
package mdu_pkg;

  localparam int DIV_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  typedef struct packed {
    logic [DIV_W-1:0] quotient;
    logic [DIV_W-1:0] remainder;
  } div_result_t;

endpackage

// File: rtl/mdu_iter_div_if.sv
// Request/result bundle between the HI/LO controller (master) and the iterative divider (slave).
interface mdu_iter_div_if
  import mdu_pkg::*;
#(
  parameter int DATA_W = DIV_W
);
  // start is a one-cycle request taken only while busy is low; operands and
  // signed_op are sampled with it. dout_valid is a one-cycle strobe with no
  // back-pressure, and dout holds its value until the next result. flush
  // abandons an operation in flight and suppresses its strobe.
  logic                start;
  logic                signed_op;
  logic [DATA_W-1:0]   dividend;
  logic [DATA_W-1:0]   divisor;
  logic                flush;
  logic                busy;
  logic                dout_valid;
  logic [2*DATA_W-1:0] dout;
  div_state_t          state;

  modport master (
    output start, signed_op, dividend, divisor, flush,
    input  busy, dout_valid, dout, state
  );

  modport slave (
    input  start, signed_op, dividend, divisor, flush,
    output busy, dout_valid, dout, state
  );
endinterface

// File: rtl/mdu_iter_div_clz.sv
// Combinational leading-zero count; an all-zero input returns DATA_W.
module mdu_div_clz #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic [DATA_W-1:0] din,
  output logic [CNT_W-1:0]  lz
);
  logic found;

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (din[i]) found = 1'b1;
        else        lz    = lz + CNT_W'(1);
      end
    end
  end
endmodule

// File: rtl/mdu_iter_div.sv
// Radix-2 restoring divider for MIPS DIV/DIVU, one quotient bit per clock.
// Define MDU_DIV_EARLY_EXIT_EN to skip the leading-zero iterations of |dividend|.
module mdu_iter_div
  import mdu_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic           clk,
  input  logic           reset,
  mdu_iter_div_if.slave  dif
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  div_state_t state_q, state_d;

  logic                signed_q, neg_q, neg_r, dz_q;
  logic [DATA_W-1:0]   dividend_q, divisor_q, div_abs_q, quo_q, rem_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] dout_q;

  logic                dividend_neg, divisor_neg;
  logic [DATA_W-1:0]   dividend_abs, divisor_abs;
  logic [DATA_W-1:0]   quo_init;
  logic [CNT_W-1:0]    cnt_init;
  logic                skip_iter;
  logic [DATA_W:0]     rem_sh;
  logic                rem_ge;
  logic [DATA_W-1:0]   rem_next, quo_fix, rem_fix;

  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign dividend_neg = signed_q & dividend_q[DATA_W-1];
  assign divisor_neg  = signed_q & divisor_q[DATA_W-1];
  assign dividend_abs = dividend_neg ? -dividend_q : dividend_q;
  assign divisor_abs  = divisor_neg  ? -divisor_q  : divisor_q;

`ifdef MDU_DIV_EARLY_EXIT_EN
  logic [CNT_W-1:0] lz;

  mdu_div_clz #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_clz (
    .din (dividend_abs),
    .lz  (lz)
  );

  assign quo_init  = dividend_abs << lz;
  assign cnt_init  = CNT_W'(DATA_W) - lz;
  assign skip_iter = (lz == CNT_W'(DATA_W));
`else
  assign quo_init  = dividend_abs;
  assign cnt_init  = CNT_W'(DATA_W);
  assign skip_iter = 1'b0;
`endif

  // The shifted remainder can exceed DATA_W bits, so compare one bit wider.
  assign rem_sh   = {rem_q, quo_q[DATA_W-1]};
  assign rem_ge   = rem_sh >= {1'b0, div_abs_q};
  assign rem_next = rem_ge ? (rem_sh[DATA_W-1:0] - div_abs_q) : rem_sh[DATA_W-1:0];

  assign quo_fix = dz_q ? '1         : (neg_q ? -quo_q : quo_q);
  assign rem_fix = dz_q ? dividend_q : (neg_r ? -rem_q : rem_q);

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dif.start && !dif.flush) state_d = PREP;
      PREP: state_d = skip_iter ? FIX : ITER;
      ITER: if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (dif.flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!dif.flush) begin
      case (state_q)
        IDLE: if (dif.start) begin
          dividend_q <= dif.dividend;
          divisor_q  <= dif.divisor;
          signed_q   <= dif.signed_op;
        end
        PREP: begin
          div_abs_q <= divisor_abs;
          quo_q     <= quo_init;
          rem_q     <= '0;
          cnt_q     <= cnt_init;
          neg_q     <= dividend_neg ^ divisor_neg;
          neg_r     <= dividend_neg;
          dz_q      <= (divisor_q == '0);
        end
        ITER: begin
          quo_q <= {quo_q[DATA_W-2:0], rem_ge};
          rem_q <= rem_next;
          cnt_q <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                              dout_q <= '0;
    else if (state_q == FIX && !dif.flush)  dout_q <= {quo_fix, rem_fix};
  end

  assign dif.busy       = (state_q != IDLE);
  assign dif.dout_valid = (state_q == DONE);
  assign dif.dout       = dout_q;
  assign dif.state      = state_q;

endmodule

// File: tb/tb_mdu_iter_div.sv
// Directed bench for mdu_iter_div: signed/unsigned results, divide-by-zero,
// overflow, latency, flush, reset abort and ignored start (MDU_DIV_EARLY_EXIT_EN aware).
module tb_mdu_iter_div;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_iter_div_if #(.DATA_W(W)) dif ();

  mdu_iter_div #(.DATA_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dif   (dif)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected edges from the start edge to the strobe.
  function automatic int lat_of(input bit s, input logic [W-1:0] a);
`ifdef MDU_DIV_EARLY_EXIT_EN
    logic [W-1:0] m;
    int lz;
    m  = (s && a[W-1]) ? -a : a;
    lz = 0;
    for (int i = W - 1; i >= 0; i--) begin
      if (m[i]) break;
      lz++;
    end
    return 2 + W - lz;
`else
    return 2 + W;
`endif
  endfunction

  function automatic logic [63:0] model(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r;
    if (b == '0) return {32'hFFFF_FFFF, a};
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  task automatic do_start(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    dif.start     = 1'b1;
    dif.signed_op = s;
    dif.dividend  = a;
    dif.divisor   = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!dif.dout_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic finish_strobe(input string tag, input logic [63:0] exp);
    chk({tag, " busy_in_done"}, dif.busy, 1'b1);
    @(posedge clk);
    #1;
    chk({tag, " strobe_one_cycle"}, dif.dout_valid, 1'b0);
    chk({tag, " busy_falls"}, dif.busy, 1'b0);
    chk({tag, " dout_holds"}, dif.dout, exp);
  endtask

  task automatic run_div(input string tag, input bit s, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [63:0] exp, input int lat);
    int n;
    do_start(s, a, b);
    wait_valid(n);
    chk({tag, " latency"}, n, lat);
    chk({tag, " result"}, dif.dout, exp);
    finish_strobe(tag, exp);
  endtask

  task automatic watch_quiet(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (dif.dout_valid || dif.busy) seen = 1'b1;
    end
    chk({tag, " quiet"}, seen, 1'b0);
  endtask

  initial begin
    int n;
    bit s;
    logic [W-1:0] a, b;
    div_result_t r;

    reset         = 1'b1;
    dif.start     = 1'b0;
    dif.signed_op = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", dif.busy, 1'b0);
    chk("reset dout_valid", dif.dout_valid, 1'b0);
    chk("reset dout", dif.dout, 64'h0);
    chk("reset state", 64'(dif.state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b0;

    // Basic unsigned and signed results with fixed-mode latency.
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 64'h0000000E_00000002, lat_of(1'b0, 32'd100));
    r = dif.dout;
    chk("struct quotient", r.quotient, 32'd14);
    chk("struct remainder", r.remainder, 32'd2);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFD_FFFF_FFFF, lat_of(1'b1, 32'hFFFF_FFF9));
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFD_0000_0001, lat_of(1'b1, 32'd7));
    run_div("div -100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'h0000_000E_FFFF_FFFE, lat_of(1'b1, 32'hFFFF_FF9C));
    run_div("divu big/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 64'h0FFF_FFFF_0000_000F, lat_of(1'b0, 32'hFFFF_FFFF));

    // Overflow and divide-by-zero.
    run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h8000_0000_0000_0000, lat_of(1'b1, 32'h8000_0000));
    run_div("divu by0", 1'b0, 32'h1234_5678, 32'h0, 64'hFFFF_FFFF_1234_5678, lat_of(1'b0, 32'h1234_5678));
    run_div("div -5/0", 1'b1, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFF_FFFF_FFFB, lat_of(1'b1, 32'hFFFF_FFFB));

    // Second start at E5 is ignored: the first operation completes at E34.
    do_start(1'b0, 32'd50, 32'd5);
    repeat (4) @(posedge clk);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 32'd7;
    dif.divisor  = 32'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    wait_valid(n);
    chk("ignored start latency", n, lat_of(1'b0, 32'd50) - 5);
    chk("ignored start result", dif.dout, 64'h0000_000A_0000_0000);
    finish_strobe("ignored start", 64'h0000_000A_0000_0000);

    // Flush sampled at E10 abandons the operation with no strobe.
    do_start(1'b0, 32'd50, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    dif.flush = 1'b1;
    @(posedge clk);
    #1;
    dif.flush = 1'b0;
    chk("flush busy", dif.busy, 1'b0);
    chk("flush state", 64'(dif.state), 64'(IDLE));
    watch_quiet("flush", 40);
    chk("flush dout kept", dif.dout, 64'h0000_000A_0000_0000);
    run_div("divu 9/4", 1'b0, 32'd9, 32'd4, 64'h0000_0002_0000_0001, lat_of(1'b0, 32'd9));

    // Reset mid-operation aborts to IDLE and clears dout.
    do_start(1'b0, 32'd1000, 32'd3);
    repeat (19) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset busy", dif.busy, 1'b0);
    chk("midreset dout_valid", dif.dout_valid, 1'b0);
    chk("midreset dout", dif.dout, 64'h0);
    chk("midreset state", 64'(dif.state), 64'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    watch_quiet("after reset", 40);

    // start and flush together in IDLE: nothing is accepted.
    @(negedge clk);
    dif.start     = 1'b1;
    dif.flush     = 1'b1;
    dif.signed_op = 1'b0;
    dif.dividend  = 32'd20;
    dif.divisor   = 32'd3;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    dif.flush = 1'b0;
    chk("start+flush busy", dif.busy, 1'b0);
    watch_quiet("start+flush", 40);

    // Small dividends: the early-exit build finishes in 5 and 2 edges.
`ifdef MDU_DIV_EARLY_EXIT_EN
    run_div("divu 5/2", 1'b0, 32'd5, 32'd2, 64'h0000_0002_0000_0001, 5);
    run_div("divu 0/3", 1'b0, 32'd0, 32'd3, 64'h0, 2);
`else
    run_div("divu 5/2", 1'b0, 32'd5, 32'd2, 64'h0000_0002_0000_0001, 34);
    run_div("divu 0/3", 1'b0, 32'd0, 32'd3, 64'h0, 34);
`endif

    // Random sweep against a reference model.
    for (int k = 0; k < 8; k++) begin
      s = 1'(($urandom_range(0, 1)));
      a = $urandom >> $urandom_range(0, 31);
      b = $urandom >> $urandom_range(0, 31);
      if (s && $urandom_range(0, 1) == 1) a = -a;
      run_div($sformatf("rand%0d", k), s, a, b, model(s, a, b), lat_of(s, a));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
